// File: rtl/router_pkg.sv
// Shared router types: packet widths, offer FSM encoding, saturating counter helper.
// Latency: n/a (types only).
// Backpressure: n/a.
package router_pkg;

    localparam int TX_PKT_W   = 29;
    localparam int RX_PKT_W   = 24;
    localparam int DROP_CNT_W = 8;

    typedef logic [TX_PKT_W-1:0]   tx_pkt_t;
    typedef logic [RX_PKT_W-1:0]   rx_pkt_t;
    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } offer_state_t;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/nic_fifo.sv
// Generic FIFO with a registered first-word-fall-through head that holds its last value when empty.
// Latency: a push into an empty FIFO is visible on head one cycle later.
// Backpressure: push while full is accepted only when a pop happens in the same cycle.
module nic_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [W-1:0]  head_q;
    logic [W-1:0]  head_nxt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The new head is either an existing entry or the word being written this
    // cycle (only when the FIFO is empty once the pop is taken into account).
    always_comb begin
        rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count_q + CW'(do_push) - CW'(do_pop);
        head_nxt   = head_q;
        if (count_nxt != '0) begin
            head_nxt = (do_push && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            head_q  <= head_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/node_if_queue.sv
// Node interface: outbound queue offered to router_core with a one-cycle gap after every take,
// inbound FWFT queue with saturating overflow drop counter. Latency: push->offer 2 edges, inbound push->read 1 edge.
// Backpressure: outbound via Node_Full; inbound has none, packets arriving on a full queue are dropped.
module node_if_queue
    import router_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                  Clk_R,
    input  logic                  Rst_n,
    input  logic                  Node_Wr_En,
    input  logic [TX_PKT_W-1:0]   Node_Wr_Packet,
    output logic                  Node_Full,
    output logic [TX_PKT_W-1:0]   Packet_From_Node,
    output logic                  Packet_From_Node_Valid,
    input  logic                  Core_Load_Ack,
    input  logic [RX_PKT_W-1:0]   Packet_To_Node,
    input  logic                  Packet_To_Node_Valid,
    input  logic                  Node_Rd_En,
    output logic [RX_PKT_W-1:0]   Node_Rd_Packet,
    output logic                  Node_Rd_Valid,
    output logic [DROP_CNT_W-1:0] Drop_Count
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    offer_state_t   state;
    tx_pkt_t        offer_pkt;
    logic           offer_vld;
    drop_cnt_t      drop_cnt;

    tx_pkt_t        tx_head;
    logic           tx_full;
    logic           tx_empty;
    logic [TX_CW-1:0] tx_count;
    logic           tx_push;
    logic           tx_pop;

    rx_pkt_t        rx_head;
    logic           rx_full;
    logic           rx_empty;
    logic [RX_CW-1:0] rx_count;
    logic           rx_drop;

    // A full outbound queue refuses writes even when the core takes the head
    // in the same cycle, so the node sees a simple full/not-full contract.
    assign tx_push = Node_Wr_En && !tx_full;
    assign tx_pop  = (state == ST_OFFER) && Core_Load_Ack;

    nic_fifo #(
        .W     (TX_PKT_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (Clk_R),
        .rst_n (Rst_n),
        .push  (tx_push),
        .din   (Node_Wr_Packet),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    nic_fifo #(
        .W     (RX_PKT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (Clk_R),
        .rst_n (Rst_n),
        .push  (Packet_To_Node_Valid),
        .din   (Packet_To_Node),
        .pop   (Node_Rd_En),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign rx_drop = Packet_To_Node_Valid && rx_full && !Node_Rd_En;

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            offer_vld <= 1'b0;
            offer_pkt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!tx_empty) begin
                        state     <= ST_OFFER;
                        offer_vld <= 1'b1;
                        offer_pkt <= tx_head;
                    end
                end
                ST_OFFER: begin
                    if (Core_Load_Ack) begin
                        state     <= ST_GAP;
                        offer_vld <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (!tx_empty) begin
                        state     <= ST_OFFER;
                        offer_vld <= 1'b1;
                        offer_pkt <= tx_head;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    offer_vld <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            drop_cnt <= '0;
        end else if (rx_drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Occupancy can never exceed the configured depth on either side.
    a_tx_count: assert property (@(posedge Clk_R) disable iff (!Rst_n)
        tx_count <= TX_CW'(TX_DEPTH));
    a_rx_count: assert property (@(posedge Clk_R) disable iff (!Rst_n)
        rx_count <= RX_CW'(RX_DEPTH));

    assign Node_Full              = tx_full;
    assign Packet_From_Node       = offer_pkt;
    assign Packet_From_Node_Valid = offer_vld;
    assign Node_Rd_Packet         = rx_head;
    assign Node_Rd_Valid          = !rx_empty;
    assign Drop_Count             = drop_cnt;

endmodule

// File: tb/tb_node_if_queue.sv
// Directed bench for node_if_queue with a queue-based reference model checked every cycle.
module tb_node_if_queue;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic        Clk_R = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Node_Wr_En = 1'b0;
    logic [28:0] Node_Wr_Packet = '0;
    logic        Node_Full;
    logic [28:0] Packet_From_Node;
    logic        Packet_From_Node_Valid;
    logic        Core_Load_Ack = 1'b0;
    logic [23:0] Packet_To_Node = '0;
    logic        Packet_To_Node_Valid = 1'b0;
    logic        Node_Rd_En = 1'b0;
    logic [23:0] Node_Rd_Packet;
    logic        Node_Rd_Valid;
    logic [7:0]  Drop_Count;

    int n_tests = 0;
    int n_fail  = 0;

    node_if_queue #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .Clk_R                  (Clk_R),
        .Rst_n                  (Rst_n),
        .Node_Wr_En             (Node_Wr_En),
        .Node_Wr_Packet         (Node_Wr_Packet),
        .Node_Full              (Node_Full),
        .Packet_From_Node       (Packet_From_Node),
        .Packet_From_Node_Valid (Packet_From_Node_Valid),
        .Core_Load_Ack          (Core_Load_Ack),
        .Packet_To_Node         (Packet_To_Node),
        .Packet_To_Node_Valid   (Packet_To_Node_Valid),
        .Node_Rd_En             (Node_Rd_En),
        .Node_Rd_Packet         (Node_Rd_Packet),
        .Node_Rd_Valid          (Node_Rd_Valid),
        .Drop_Count             (Drop_Count)
    );

    always #5 Clk_R = ~Clk_R;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outbound offer is raised whenever something was queued
    // before the edge, and drops for exactly one cycle after every take.
    logic [28:0] tq[$];
    logic [23:0] rq[$];
    bit          m_valid = 0;
    int          m_drop = 0;
    logic [23:0] m_rd_last = '0;
    int          pre_t, pre_r;
    bit          acc_t, pop_r, push_r;

    always @(posedge Clk_R) begin
        if (Rst_n) begin
            pre_t = tq.size();
            acc_t = Node_Wr_En && (pre_t < TXD);
            if (m_valid) begin
                if (Core_Load_Ack) begin
                    void'(tq.pop_front());
                    m_valid = 0;
                end
            end else begin
                m_valid = (pre_t > 0);
            end
            if (acc_t) tq.push_back(Node_Wr_Packet);

            pre_r  = rq.size();
            pop_r  = Node_Rd_En && (pre_r > 0);
            push_r = Packet_To_Node_Valid && ((pre_r < RXD) || Node_Rd_En);
            if (Packet_To_Node_Valid && !push_r && m_drop < 255) m_drop++;
            if (pop_r) void'(rq.pop_front());
            if (push_r) rq.push_back(Packet_To_Node);
            if (rq.size() > 0) m_rd_last = rq[0];
        end
    end

    always @(negedge Rst_n) begin
        tq.delete();
        rq.delete();
        m_valid   = 0;
        m_drop    = 0;
        m_rd_last = '0;
    end

    always @(negedge Clk_R) begin
        check("m_full",    32'(Node_Full),              32'(tq.size() == TXD));
        check("m_valid",   32'(Packet_From_Node_Valid), 32'(m_valid));
        if (m_valid) check("m_pkt", 32'(Packet_From_Node), 32'(tq[0]));
        check("m_rd_vld",  32'(Node_Rd_Valid),          32'(rq.size() > 0));
        check("m_rd_pkt",  32'(Node_Rd_Packet),         32'(m_rd_last));
        check("m_drop",    32'(Drop_Count),             32'(m_drop));
    end

    task automatic step(input logic wr, input logic [28:0] wp, input logic ack,
                        input logic tv, input logic [23:0] tp, input logic rd);
        Node_Wr_En           = wr;
        Node_Wr_Packet       = wp;
        Core_Load_Ack        = ack;
        Packet_To_Node_Valid = tv;
        Packet_To_Node       = tp;
        Node_Rd_En           = rd;
        @(negedge Clk_R);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    logic [28:0] tx_pk [4];
    logic [23:0] rx_exp [4];
    logic        vpat [8];

    initial begin
        tx_pk[0] = 29'h1000_0001; tx_pk[1] = 29'h0AAA_AAA2;
        tx_pk[2] = 29'h1555_5553; tx_pk[3] = 29'h0000_0004;
        rx_exp[0] = 24'h222222; rx_exp[1] = 24'h333333;
        rx_exp[2] = 24'h444444; rx_exp[3] = 24'h666666;
        vpat[0] = 0; vpat[1] = 1; vpat[2] = 0; vpat[3] = 1;
        vpat[4] = 0; vpat[5] = 1; vpat[6] = 0; vpat[7] = 0;

        repeat (2) @(negedge Clk_R);
        check("rst_valid", 32'(Packet_From_Node_Valid), 32'd0);
        check("rst_pkt",   32'(Packet_From_Node),       32'd0);
        check("rst_full",  32'(Node_Full),              32'd0);
        check("rst_rdvld", 32'(Node_Rd_Valid),          32'd0);
        check("rst_rdpkt", 32'(Node_Rd_Packet),         32'd0);
        check("rst_drop",  32'(Drop_Count),             32'd0);
        Rst_n = 1'b1;
        idle();

        // single packet: offer one cycle after push, held until ack
        step(1'b1, 29'h1ABCDEF0, 1'b0, 1'b0, '0, 1'b0);
        check("one_lat0", 32'(Packet_From_Node_Valid), 32'd0);
        idle();
        check("one_vld",  32'(Packet_From_Node_Valid), 32'd1);
        check("one_pkt",  32'(Packet_From_Node),       32'h1ABCDEF0);
        idle();
        check("one_hold", 32'(Packet_From_Node),       32'h1ABCDEF0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("one_ack",  32'(Packet_From_Node_Valid), 32'd0);
        idle();
        check("one_idle", 32'(Packet_From_Node_Valid), 32'd0);

        // four back-to-back pushes, fifth refused while full
        for (int i = 0; i < 4; i++) step(1'b1, tx_pk[i], 1'b0, 1'b0, '0, 1'b0);
        check("fill_full", 32'(Node_Full), 32'd1);
        step(1'b1, 29'h1FFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        check("fill_full5", 32'(Node_Full), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) check("order_pkt", 32'(Packet_From_Node), 32'(tx_pk[(k-1)/2]));
            step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            check("gap_pattern", 32'(Packet_From_Node_Valid), 32'(vpat[k-1]));
        end
        check("drain_full", 32'(Node_Full), 32'd0);

        // ack in IDLE and in GAP must not pop
        step(1'b1, 29'h0123_4567, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 29'h0765_4321, 1'b1, 1'b0, '0, 1'b0);
        check("idle_ack_vld", 32'(Packet_From_Node_Valid), 32'd1);
        check("idle_ack_pkt", 32'(Packet_From_Node),       32'h0123_4567);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("take_a", 32'(Packet_From_Node_Valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("gap_ack_vld", 32'(Packet_From_Node_Valid), 32'd1);
        check("gap_ack_pkt", 32'(Packet_From_Node),       32'h0765_4321);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        idle();
        check("ab_done", 32'(Packet_From_Node_Valid), 32'd0);

        // inbound: five arrivals, no reads -> one drop
        for (int i = 1; i <= 5; i++) step(1'b0, '0, 1'b0, 1'b1, 24'(i * 24'h111111), 1'b0);
        check("in_vld",  32'(Node_Rd_Valid),  32'd1);
        check("in_head", 32'(Node_Rd_Packet), 32'h111111);
        check("in_drop", 32'(Drop_Count),     32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 24'h666666, 1'b1);
        check("in_fullrd_drop", 32'(Drop_Count),     32'd1);
        for (int i = 0; i < 4; i++) begin
            check("in_order", 32'(Node_Rd_Packet), 32'(rx_exp[i]));
            step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        check("in_empty",    32'(Node_Rd_Valid),  32'd0);
        check("in_holdlast", 32'(Node_Rd_Packet), 32'h666666);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("in_rd_empty", 32'(Node_Rd_Packet), 32'h666666);
        step(1'b0, '0, 1'b0, 1'b1, 24'h777777, 1'b1);
        check("in_pushpop_empty_vld", 32'(Node_Rd_Valid),  32'd1);
        check("in_pushpop_empty_pkt", 32'(Node_Rd_Packet), 32'h777777);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        // overflow saturation
        for (int i = 0; i < 304; i++) step(1'b0, '0, 1'b0, 1'b1, 24'(i), 1'b0);
        check("sat_255", 32'(Drop_Count), 32'd255);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 24'hABCDEF, 1'b0);
        check("sat_stay", 32'(Drop_Count), 32'd255);

        // reset mid-offer with three queued
        for (int i = 0; i < 3; i++) step(1'b1, 29'(29'h0C00_0000 + i), 1'b0, 1'b0, '0, 1'b0);
        check("pre_rst_vld", 32'(Packet_From_Node_Valid), 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("rst_mid_vld",   32'(Packet_From_Node_Valid), 32'd0);
        check("rst_mid_full",  32'(Node_Full),              32'd0);
        check("rst_mid_pkt",   32'(Packet_From_Node),       32'd0);
        check("rst_mid_rdvld", 32'(Node_Rd_Valid),          32'd0);
        check("rst_mid_drop",  32'(Drop_Count),             32'd0);
        @(negedge Clk_R);
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("post_rst_quiet", 32'(Packet_From_Node_Valid), 32'd0);
        end
        step(1'b1, 29'h0F0F_0F0F, 1'b0, 1'b0, '0, 1'b0);
        idle();
        check("post_rst_vld", 32'(Packet_From_Node_Valid), 32'd1);
        check("post_rst_pkt", 32'(Packet_From_Node),       32'h0F0F_0F0F);
        repeat (3) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
